// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: instruction fetch, PC update, decode and datapath/memory sequencing.
// Latency: 4-10 cycles per instruction; a state change appears one clock after the deciding edge.
// Backpressure: none; the memory is assumed to answer a read in the second held MREAD cycle.
module cpu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_ir,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // S_ALU_M is the ALU step for MOV reg / MVN (A forced to 0). Splitting it from
    // S_ALU keeps every output a pure function of the state register.
    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
        S_WRI, S_GETA, S_GETB, S_ALU, S_ALU_M, S_WRD, S_CMP,
        S_ADDR, S_LDADDR, S_MRD1, S_MRD2, S_GETBD, S_PASSB, S_MWR,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    // Instruction class decode from the IR fields (valid from S_UPC onward).
    logic is_mov_imm, is_mov_reg, is_add, is_cmp, is_and, is_mvn, is_ldr, is_str, is_halt;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_add     = (opcode == 3'b101) && (op == 2'b00);
    assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);
    assign is_and     = (opcode == 3'b101) && (op == 2'b10);
    assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
    assign is_ldr     = (opcode == 3'b011) && (op == 2'b00);
    assign is_str     = (opcode == 3'b100) && (op == 2'b00);
    assign is_halt    = (opcode == 3'b111);

    // State register; synchronous reset overrides everything, even mid memory access.
    always_ff @(posedge clk) begin
        if (reset) state <= S_RST;
        else       state <= state_nxt;
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:    state_nxt = S_IF1;
            S_IF1:    state_nxt = S_IF2;
            S_IF2:    state_nxt = S_UPC;
            S_UPC:    state_nxt = S_DEC;
            S_DEC: begin
                if (is_mov_imm)                                  state_nxt = S_WRI;
                else if (is_mov_reg || is_mvn)                   state_nxt = S_GETB;
                else if (is_add || is_and || is_cmp || is_ldr || is_str)
                                                                 state_nxt = S_GETA;
                else if (is_halt)                                state_nxt = S_HALT;
                else                                             state_nxt = S_IF1;
            end
            S_WRI:    state_nxt = S_IF1;
            S_GETA:   state_nxt = (is_ldr || is_str) ? S_ADDR : S_GETB;
            S_GETB: begin
                if (is_cmp)                    state_nxt = S_CMP;
                else if (is_mov_reg || is_mvn) state_nxt = S_ALU_M;
                else                           state_nxt = S_ALU;
            end
            S_ALU:    state_nxt = S_WRD;
            S_ALU_M:  state_nxt = S_WRD;
            S_WRD:    state_nxt = S_IF1;
            S_CMP:    state_nxt = S_IF1;
            S_ADDR:   state_nxt = S_LDADDR;
            S_LDADDR: state_nxt = is_ldr ? S_MRD1 : S_GETBD;
            S_MRD1:   state_nxt = S_MRD2;
            S_MRD2:   state_nxt = S_IF1;
            S_GETBD:  state_nxt = S_PASSB;
            S_PASSB:  state_nxt = S_MWR;
            S_MWR:    state_nxt = S_IF1;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_RST;
        endcase
    end

    // Moore output decode; everything defaults to inactive.
    always_comb begin
        nsel      = NSEL_NONE;
        vsel      = VSEL_C;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        write     = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        addr_sel  = 1'b0;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = MEM_NONE;
        halted    = 1'b0;
        case (state)
            S_RST:    begin reset_pc = 1'b1; load_pc = 1'b1; end
            S_IF1:    begin addr_sel = 1'b1; mem_cmd = MEM_READ; end
            S_IF2:    begin addr_sel = 1'b1; mem_cmd = MEM_READ; load_ir = 1'b1; end
            S_UPC:    load_pc = 1'b1;
            S_WRI:    begin nsel = NSEL_RN; vsel = VSEL_IMM; write = 1'b1; end
            S_GETA:   begin nsel = NSEL_RN; loada = 1'b1; end
            S_GETB:   begin nsel = NSEL_RM; loadb = 1'b1; end
            S_ALU:    loadc = 1'b1;
            S_ALU_M:  begin asel = 1'b1; loadc = 1'b1; end
            S_WRD:    begin nsel = NSEL_RD; vsel = VSEL_C; write = 1'b1; end
            S_CMP:    loads = 1'b1;
            S_ADDR:   begin bsel = 1'b1; loadc = 1'b1; end
            S_LDADDR: load_addr = 1'b1;
            S_MRD1:   mem_cmd = MEM_READ;
            S_MRD2:   begin
                mem_cmd = MEM_READ;
                nsel    = NSEL_RD;
                vsel    = VSEL_MDATA;
                write   = 1'b1;
            end
            S_GETBD:  begin nsel = NSEL_RD; loadb = 1'b1; end
            S_PASSB:  begin asel = 1'b1; loadc = 1'b1; end
            S_MWR:    mem_cmd = MEM_WRITE;
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector table, reset/halt corner sequences,
// then random instruction streams checked against a per-class cycle-trace model.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven at the same point.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel, write;
    logic       load_pc, reset_pc, addr_sel, load_ir, load_addr, halted;
    logic [1:0] mem_cmd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op),
        .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .write(write), .load_pc(load_pc),
        .reset_pc(reset_pc), .addr_sel(addr_sel), .load_ir(load_ir),
        .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted)
    );

    // All outputs packed into one word for comparison.
    logic [19:0] got;
    assign got = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
                  load_pc, reset_pc, addr_sel, load_ir, load_addr, mem_cmd, halted};

    localparam logic [19:0] HLT   = 20'h00001;
    localparam logic [19:0] MRD   = 20'h00002;
    localparam logic [19:0] MWR   = 20'h00004;
    localparam logic [19:0] LADR  = 20'h00008;
    localparam logic [19:0] LIR   = 20'h00010;
    localparam logic [19:0] ASL   = 20'h00020;
    localparam logic [19:0] RPC   = 20'h00040;
    localparam logic [19:0] LPC   = 20'h00080;
    localparam logic [19:0] WR    = 20'h00100;
    localparam logic [19:0] BS    = 20'h00200;
    localparam logic [19:0] AS    = 20'h00400;
    localparam logic [19:0] LS    = 20'h00800;
    localparam logic [19:0] LC    = 20'h01000;
    localparam logic [19:0] LB    = 20'h02000;
    localparam logic [19:0] LA    = 20'h04000;
    localparam logic [19:0] V_IMM = 20'h10000;
    localparam logic [19:0] V_MD  = 20'h18000;
    localparam logic [19:0] N_RN  = 20'h20000;
    localparam logic [19:0] N_RD  = 20'h40000;
    localparam logic [19:0] N_RM  = 20'h80000;

    localparam logic [19:0] O_RST = RPC | LPC;
    localparam logic [19:0] O_IF1 = ASL | MRD;
    localparam logic [19:0] O_IF2 = ASL | MRD | LIR;
    localparam logic [19:0] O_UPC = LPC;
    localparam logic [19:0] O_DEC = 20'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [19:0] exp, input string nm, input int cyc);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%05h exp=%05h", nm, cyc, got, exp);
        end
    endtask

    // Reference: expected output word for every cycle from S_IF1 until the next S_IF1
    // (exclusive), built from the instruction class. HALT yields the fetch plus 20 halted cycles.
    function automatic void exp_seq(input logic [2:0] opc, input logic [1:0] o,
                                    output logic [19:0] q[$]);
        q = {O_IF1, O_IF2, O_UPC, O_DEC};
        if (opc == 3'b111) begin
            for (int k = 0; k < 20; k++) q.push_back(HLT);
        end else if (opc == 3'b110 && o == 2'b10) begin            // MOV imm
            q.push_back(N_RN | V_IMM | WR);
        end else if ((opc == 3'b110 && o == 2'b00) || (opc == 3'b101 && o == 2'b11)) begin
            q.push_back(N_RM | LB);                                 // MOV reg / MVN
            q.push_back(LC | AS);
            q.push_back(N_RD | WR);
        end else if (opc == 3'b101 && o == 2'b01) begin             // CMP
            q.push_back(N_RN | LA);
            q.push_back(N_RM | LB);
            q.push_back(LS);
        end else if (opc == 3'b101) begin                           // ADD / AND
            q.push_back(N_RN | LA);
            q.push_back(N_RM | LB);
            q.push_back(LC);
            q.push_back(N_RD | WR);
        end else if (opc == 3'b011 && o == 2'b00) begin             // LDR
            q.push_back(N_RN | LA);
            q.push_back(BS | LC);
            q.push_back(LADR);
            q.push_back(MRD);
            q.push_back(MRD | N_RD | V_MD | WR);
        end else if (opc == 3'b100 && o == 2'b00) begin             // STR
            q.push_back(N_RN | LA);
            q.push_back(BS | LC);
            q.push_back(LADR);
            q.push_back(N_RD | LB);
            q.push_back(AS | LC);
            q.push_back(MWR);
        end
    endfunction

    function automatic int exp_cpi(input logic [2:0] opc, input logic [1:0] o);
        if (opc == 3'b110 && o == 2'b10) return 5;
        if (opc == 3'b110 && o == 2'b00) return 7;
        if (opc == 3'b101) return (o == 2'b00 || o == 2'b10) ? 8 : 7;
        if (opc == 3'b011 && o == 2'b00) return 9;
        if (opc == 3'b100 && o == 2'b00) return 10;
        return 4;
    endfunction

    // Runs one instruction starting in S_IF1; fetch cycles see junk on opcode/op.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input string nm);
        logic [19:0] q[$];
        int          ncyc;
        exp_seq(opc, o, q);
        ncyc = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (i < 2) begin
                opcode = 3'($urandom_range(0, 7));
                op     = 2'($urandom_range(0, 3));
            end else begin
                opcode = opc;
                op     = o;
            end
            check(q[i], nm, i);
            n_chk++;
            if (write && mem_cmd == 2'b10) begin
                n_fail++;
                $display("FAIL %s_wr_mwr cyc=%0d got=%05h exp=no write+MWRITE", nm, i, got);
            end
            step();
            ncyc++;
        end
        n_chk++;
        if (ncyc != exp_cpi(opc, o)) begin
            n_fail++;
            $display("FAIL %s_cpi got=%0d exp=%0d", nm, ncyc, exp_cpi(opc, o));
        end
        check(O_IF1, {nm, "_next_if1"}, ncyc);
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  opc;
        logic [1:0]  o;
        logic [19:0] exp;
    } vec_t;

    initial begin
        vec_t        vt[12];
        logic [19:0] q[$];
        logic [2:0]  ropc;
        logic [1:0]  rop;

        reset  = 1'b1;
        opcode = 3'b000;
        op     = 2'b00;

        // Directed table: reset, MOV R0,#7, then a NOP.
        vt[0]  = '{1'b1, 3'b000, 2'b00, O_RST};
        vt[1]  = '{1'b1, 3'b000, 2'b00, O_RST};
        vt[2]  = '{1'b0, 3'b110, 2'b10, O_IF1};
        vt[3]  = '{1'b0, 3'b110, 2'b10, O_IF2};
        vt[4]  = '{1'b0, 3'b110, 2'b10, O_UPC};
        vt[5]  = '{1'b0, 3'b110, 2'b10, O_DEC};
        vt[6]  = '{1'b0, 3'b110, 2'b10, N_RN | V_IMM | WR};
        vt[7]  = '{1'b0, 3'b000, 2'b00, O_IF1};
        vt[8]  = '{1'b0, 3'b000, 2'b00, O_IF2};
        vt[9]  = '{1'b0, 3'b000, 2'b00, O_UPC};
        vt[10] = '{1'b0, 3'b000, 2'b00, O_DEC};
        vt[11] = '{1'b0, 3'b000, 2'b00, O_IF1};
        for (int i = 0; i < 12; i++) begin
            reset  = vt[i].rst;
            opcode = vt[i].opc;
            op     = vt[i].o;
            step();
            check(vt[i].exp, "table", i);
        end

        // One of each class in a fixed order.
        run_instr(3'b101, 2'b00, "add");
        run_instr(3'b101, 2'b01, "cmp");
        run_instr(3'b101, 2'b10, "and");
        run_instr(3'b101, 2'b11, "mvn");
        run_instr(3'b110, 2'b00, "movreg");
        run_instr(3'b011, 2'b00, "ldr");
        run_instr(3'b100, 2'b00, "str");
        run_instr(3'b010, 2'b01, "nop");

        // Reset held for two cycles while in S_MRD1 of an LDR.
        exp_seq(3'b011, 2'b00, q);
        for (int i = 0; i < 7; i++) begin
            opcode = 3'b011;
            op     = 2'b00;
            check(q[i], "ldr_pre_rst", i);
            step();
        end
        check(MRD, "ldr_mrd1", 7);
        reset = 1'b1;
        step();
        check(O_RST, "rst_mid_mrd1_a", 0);
        step();
        check(O_RST, "rst_mid_mrd1_b", 1);
        reset = 1'b0;
        step();
        check(O_IF1, "rst_then_if1", 2);

        // HALT: 20 cycles of halted with no memory command, then reset clears it.
        exp_seq(3'b111, 2'b01, q);
        for (int i = 0; i < q.size(); i++) begin
            opcode = (i < 2) ? 3'b000 : 3'b111;
            op     = 2'b01;
            check(q[i], "halt", i);
            step();
        end
        check(HLT, "halt_stays", 24);
        reset = 1'b1;
        step();
        check(O_RST, "halt_reset", 0);
        reset = 1'b0;
        step();
        check(O_IF1, "halt_reset_if1", 1);
        n_chk++;
        if (halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halted_after_reset got=%b exp=0", halted);
        end

        // Random instruction stream (HALT excluded so the stream keeps running).
        for (int n = 0; n < 60; n++) begin
            ropc = 3'($urandom_range(0, 6));
            rop  = 2'($urandom_range(0, 3));
            run_instr(ropc, rop, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
